// File: rtl/enemy_fire_scheduler.sv
// Round-robin enemy fire scheduler: one shot opportunity per cooldown window,
// shared fairly among the enemies that are alive and have no bullet in flight.
module enemy_fire_scheduler #(
    parameter int unsigned N_ENEMY       = 7,
    parameter int unsigned COOLDOWN      = 15,
    parameter int unsigned BOSS_COOLDOWN = 8
) (
    input  logic               clk_30hz,
    input  logic               RST,
    input  logic               enable,
    input  logic [N_ENEMY-1:0] alive,
    input  logic [N_ENEMY-1:0] bullet_busy,
    input  logic               bossActive,
    output logic [N_ENEMY-1:0] fire_grant,
    output logic [2:0]         last_grant,
    output logic [4:0]         cooldown,
    output logic [7:0]         shots_fired
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CD_W  = 5;
    localparam int unsigned SH_W  = 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COOL = 2'd1;
    localparam logic [1:0] S_ARB  = 2'd2;
    localparam logic [1:0] S_FIRE = 2'd3;

    logic [1:0]         state_q,      state_d;
    logic [N_ENEMY-1:0] fire_grant_q, fire_grant_d;
    logic [IDX_W-1:0]   last_grant_q, last_grant_d;
    logic [CD_W-1:0]    cooldown_q,   cooldown_d;
    logic [SH_W-1:0]    shots_q,      shots_d;

    logic [N_ENEMY-1:0] cand;
    logic               found;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic [CD_W-1:0]    reload;

    assign reload = bossActive ? CD_W'(BOSS_COOLDOWN) : CD_W'(COOLDOWN);

    // Round-robin search starting just after the last winner; last winner checked last.
    always_comb begin
        cand   = alive & ~bullet_busy;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 1; k <= N_ENEMY; k++) begin
            idx = IDX_W'((32'(last_grant_q) + k) % N_ENEMY);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        fire_grant_d = '0;
        last_grant_d = last_grant_q;
        cooldown_d   = cooldown_q;
        shots_d      = shots_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d    = S_COOL;
                    cooldown_d = reload;
                end
            end
            S_COOL: begin
                if (!enable) begin
                    state_d    = S_IDLE;
                    cooldown_d = '0;
                end else if (cooldown_q == CD_W'(1)) begin
                    state_d    = S_ARB;
                    cooldown_d = '0;
                end else begin
                    cooldown_d = cooldown_q - CD_W'(1);
                end
            end
            S_ARB: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (found) begin
                    state_d              = S_FIRE;
                    fire_grant_d[winner] = 1'b1;
                    last_grant_d         = winner;
                    shots_d              = (shots_q == '1) ? shots_q : shots_q + SH_W'(1);
                end
            end
            S_FIRE: begin
                if (enable) begin
                    state_d    = S_COOL;
                    cooldown_d = reload;
                end else begin
                    state_d    = S_IDLE;
                    cooldown_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_30hz) begin
        if (RST) begin
            state_q      <= S_IDLE;
            fire_grant_q <= '0;
            last_grant_q <= IDX_W'(N_ENEMY - 1);
            cooldown_q   <= '0;
            shots_q      <= '0;
        end else begin
            state_q      <= state_d;
            fire_grant_q <= fire_grant_d;
            last_grant_q <= last_grant_d;
            cooldown_q   <= cooldown_d;
            shots_q      <= shots_d;
        end
    end

    assign fire_grant  = fire_grant_q;
    assign last_grant  = last_grant_q;
    assign cooldown    = cooldown_q;
    assign shots_fired = shots_q;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Scoreboard bench for enemy_fire_scheduler; a second short-cooldown instance covers saturation.
module tb_enemy_fire_scheduler;

    logic       clk_30hz = 1'b0;
    logic       RST      = 1'b1;
    logic       enable   = 1'b0;
    logic       en_s     = 1'b0;
    logic [6:0] alive    = '0;
    logic [6:0] bullet_busy = '0;
    logic       bossActive  = 1'b0;

    logic [6:0] fire_grant,  fire_grant_s;
    logic [2:0] last_grant,  last_grant_s;
    logic [4:0] cooldown,    cooldown_s;
    logic [7:0] shots_fired, shots_fired_s;

    enemy_fire_scheduler dut (
        .clk_30hz    (clk_30hz),
        .RST         (RST),
        .enable      (enable),
        .alive       (alive),
        .bullet_busy (bullet_busy),
        .bossActive  (bossActive),
        .fire_grant  (fire_grant),
        .last_grant  (last_grant),
        .cooldown    (cooldown),
        .shots_fired (shots_fired)
    );

    enemy_fire_scheduler #(.COOLDOWN(1)) dut_sat (
        .clk_30hz    (clk_30hz),
        .RST         (RST),
        .enable      (en_s),
        .alive       (alive),
        .bullet_busy (bullet_busy),
        .bossActive  (bossActive),
        .fire_grant  (fire_grant_s),
        .last_grant  (last_grant_s),
        .cooldown    (cooldown_s),
        .shots_fired (shots_fired_s)
    );

    always #5 clk_30hz = ~clk_30hz;

    int unsigned cyc = 0;
    always @(posedge clk_30hz) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [6:0]  grant;
        logic [2:0]  last;
        logic [7:0]  shots;
    } exp_t;

    exp_t sbq[$];
    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int unsigned c, input int unsigned w, input int unsigned s);
        exp_t e;
        e.cyc   = c;
        e.grant = 7'(1) << w;
        e.last  = 3'(w);
        e.shots = 8'(s);
        sbq.push_back(e);
    endfunction

    // Every grant pulse on the main instance must match the head of the scoreboard.
    always @(negedge clk_30hz) begin
        if (fire_grant !== 7'd0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_grant", 32'(fire_grant), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("grant_cycle", cyc, e.cyc);
                chk("grant_vec", 32'(fire_grant), 32'(e.grant));
                chk("grant_last", 32'(last_grant), 32'(e.last));
                chk("grant_shots", 32'(shots_fired), 32'(e.shots));
            end
        end
    end

    task automatic do_reset();
        @(posedge clk_30hz); #1;
        RST = 1'b1; enable = 1'b0; en_s = 1'b0; bossActive = 1'b0;
        alive = '0; bullet_busy = '0;
        @(posedge clk_30hz); #1;
        RST = 1'b0;
    endtask

    task automatic wait_cycle(input int unsigned target);
        while (cyc < target) @(negedge clk_30hz);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk_30hz);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("scoreboard_timeout", 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    int unsigned c0, c1;

    initial begin
        // Reset values
        repeat (2) @(posedge clk_30hz);
        @(negedge clk_30hz);
        chk("rst_grant", 32'(fire_grant), 32'd0);
        chk("rst_last", 32'(last_grant), 32'd6);
        chk("rst_cool", 32'(cooldown), 32'd0);
        chk("rst_shots", 32'(shots_fired), 32'd0);

        // Basic round-robin, period 17
        do_reset();
        alive = 7'h7F; enable = 1'b1; c0 = cyc;
        for (int k = 1; k <= 8; k++) push_exp(c0 + 17 * k, (k - 1) % 7, k);
        wait_cycle(c0 + 1);
        chk("rr_cool_load", 32'(cooldown), 32'd15);
        wait_cycle(c0 + 16);
        chk("rr_arb_cool", 32'(cooldown), 32'd0);
        drain(200);

        // Sparse alive set alternates enemies 2 and 4
        do_reset();
        alive = 7'b0010100; enable = 1'b1; c0 = cyc;
        for (int k = 1; k <= 4; k++) push_exp(c0 + 17 * k, (k % 2 == 1) ? 2 : 4, k);
        drain(100);

        // All blocked: no grant for 50 cycles, then enemy 3 freed
        do_reset();
        alive = 7'h7F; bullet_busy = 7'h7F; enable = 1'b1; c0 = cyc;
        wait_cycle(c0 + 40);
        chk("blk_cool", 32'(cooldown), 32'd0);
        chk("blk_grant", 32'(fire_grant), 32'd0);
        wait_cycle(c0 + 66);
        @(posedge clk_30hz); #1;
        bullet_busy = 7'h77;
        push_exp(cyc + 1, 3, 1);
        drain(5);

        // Boss phase, period 10
        do_reset();
        alive = 7'h7F; bossActive = 1'b1; enable = 1'b1; c0 = cyc;
        for (int k = 1; k <= 3; k++) push_exp(c0 + 10 * k, k - 1, k);
        wait_cycle(c0 + 1);
        chk("boss_cool_load", 32'(cooldown), 32'd8);
        wait_cycle(c0 + 11);
        chk("boss_cool_reload", 32'(cooldown), 32'd8);
        drain(50);

        // Enable drop mid-cooldown, boss toggle mid-count, reset during FIRE
        do_reset();
        alive = 7'h7F; enable = 1'b1; c0 = cyc;
        wait_cycle(c0 + 9);
        chk("drop_cool7", 32'(cooldown), 32'd7);
        enable = 1'b0;
        wait_cycle(c0 + 10);
        chk("drop_idle_cool", 32'(cooldown), 32'd0);
        wait_cycle(c0 + 11);
        chk("drop_stay_idle", 32'(cooldown), 32'd0);
        @(posedge clk_30hz); #1;
        enable = 1'b1; c1 = cyc;
        push_exp(c1 + 17, 0, 1);
        push_exp(c1 + 27, 1, 2);
        wait_cycle(c1 + 5);
        bossActive = 1'b1;
        wait_cycle(c1 + 6);
        chk("boss_midcount", 32'(cooldown), 32'd10);
        wait_cycle(c1 + 27);
        RST = 1'b1;
        @(negedge clk_30hz);
        chk("fire_rst_grant", 32'(fire_grant), 32'd0);
        chk("fire_rst_last", 32'(last_grant), 32'd6);
        chk("fire_rst_shots", 32'(shots_fired), 32'd0);
        chk("fire_rst_cool", 32'(cooldown), 32'd0);
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        // Saturation on the COOLDOWN=1 instance, period 3
        do_reset();
        alive = 7'h7F; en_s = 1'b1; c0 = cyc;
        wait_cycle(c0 + 3);
        chk("sat_first_grant", 32'(fire_grant_s), 32'h01);
        wait_cycle(c0 + 3 * 254);
        chk("sat_shots254", 32'(shots_fired_s), 32'd254);
        chk("sat_grant254", 32'(fire_grant_s), 32'h02);
        wait_cycle(c0 + 3 * 255);
        chk("sat_shots255", 32'(shots_fired_s), 32'd255);
        wait_cycle(c0 + 3 * 300);
        chk("sat_shots_hold", 32'(shots_fired_s), 32'd255);
        chk("sat_grant300", 32'(fire_grant_s), 32'h20);
        chk("sat_last300", 32'(last_grant_s), 32'd5);
        chk("main_quiet", 32'(fire_grant), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
